// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Sequential instruction fetch stage with a small prefetch queue.
//   Fetch requests go out as word addresses over a valid/ready channel. The
//   memory answers in order, at least one cycle after it accepts a request.
//   Each kept response is stored in a queue with its pc. Decode drains the
//   queue through a valid/ready handshake. A redirect flushes the queue and
//   restarts fetch at the target. Any responses still in flight at that point
//   are counted and discarded as they arrive.
// Ports
//   clk_i, rst_i                 clock; synchronous active-high reset
//   redirect_valid_i/pc_i        redirect request and target (bits [1:0] ignored)
//   imem_req_valid_o/addr_o      fetch request toward memory
//   imem_req_ready_i             memory accepts the request
//   imem_rsp_valid_i/data_i      in-order instruction response
//   instr_valid_o/instr_o/pc_o   queue head toward decode (zeros when empty)
//   instr_ready_i                decode accepts the head
module fetch_prefetch_unit #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = 32'h8000_0000,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          q_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, outstanding, drop;
    logic [XLEN-1:0] fetch_pc, rsp_pc;

    logic            req_fire, push, pop;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   outstanding_rsp;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_pc_unused;

    assign redirect_target    = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign redirect_pc_unused = |redirect_pc_i[1:0];

    // Every in-flight request owns a queue slot, including ones that will
    // be dropped. A kept response therefore always finds room.
    assign credit_used      = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid_o = !rst_i && !redirect_valid_i && (credit_used < DEPTH_W);
    assign imem_req_addr_o  = fetch_pc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? q_mem[rd_ptr].instr : '0;
    assign pc_o          = instr_valid_o ? q_mem[rd_ptr].pc    : '0;
    assign pop           = instr_valid_o && instr_ready_i;

    // A response arriving in a redirect cycle belongs to the old stream.
    assign push = imem_rsp_valid_i && (drop == '0) && !redirect_valid_i;

    // In-flight count once this cycle's response has been retired.
    // A redirect sets this as the number of responses still to discard.
    assign outstanding_rsp = outstanding - CW'(imem_rsp_valid_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_rsp + CW'(req_fire);
            if (redirect_valid_i) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                drop     <= outstanding_rsp;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (imem_rsp_valid_i && drop != '0)
                    drop <= drop - CW'(1);
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push)
            q_mem[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data_i};
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && count == DEPTH_C));
    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rsp_valid_i && outstanding == '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;
    localparam int          XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          FIFO_DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    always #5 clk_i = ~clk_i;

    fetch_prefetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1;
    int last_due = 0;

    // memory model: pending in-order responses
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    // observation logs
    logic [31:0] iss[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_ins[$];
    // values sampled mid-cycle
    logic        s_rv, s_iv;
    logic [31:0] s_ra, s_pc, s_in;
    // stream scoreboard
    bit          sb_on = 0;
    logic [31:0] exp_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        iss.delete(); dlv_pc.delete(); dlv_ins.delete();
    endtask

    // One clock cycle: drive the memory response, sample outputs at the
    // falling edge, record handshakes, then advance past the rising edge.
    task automatic cycle();
        int d;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_data(mq_addr[0]);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
        end
        @(negedge clk_i);
        s_rv = imem_req_valid_o; s_ra = imem_req_addr_o;
        s_iv = instr_valid_o;    s_pc = pc_o;  s_in = instr_o;
        if (imem_rsp_valid_i) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (rst_i) begin
            mq_addr.delete(); mq_due.delete();
            last_due = cyc;
        end else begin
            if (s_rv && imem_req_ready_i) begin
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq_addr.push_back(s_ra);
                mq_due.push_back(d);
                iss.push_back(s_ra);
            end
            if (s_iv && instr_ready_i) begin
                dlv_pc.push_back(s_pc);
                dlv_ins.push_back(s_in);
                if (sb_on) begin
                    chk("sb_pc", s_pc, exp_pc);
                    chk("sb_instr", s_in, mem_data(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (redirect_valid_i)
                exp_pc = {redirect_pc_i[31:2], 2'b00};
        end
        @(posedge clk_i); #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; redirect_valid_i = 1'b0;
        cycle(); cycle();
        rst_i = 1'b0;
        exp_pc = RESET_PC;
        clr();
    endtask

    initial begin
        logic [31:0] a;
        rst_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        instr_ready_i = 1'b0;
        @(posedge clk_i); #1;

        // reset state
        cycle();
        chk("rst_req_valid", s_rv, 0);
        chk("rst_req_addr", s_ra, RESET_PC);
        chk("rst_instr_valid", s_iv, 0);
        chk("rst_pc", s_pc, 0);
        chk("rst_instr", s_in, 0);

        // 1: streaming at one instruction per cycle
        rst_i = 1'b0; imem_req_ready_i = 1'b1; instr_ready_i = 1'b1;
        lat_min = 1; lat_max = 1; clr();
        cycle();
        chk("t1_iv_c0", s_iv, 0);
        chk("t1_rv_c0", s_rv, 1);
        chk("t1_addr_c0", s_ra, RESET_PC);
        cycle();
        chk("t1_iv_c1", s_iv, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            a = RESET_PC + 32'(4 * i);
            chk("t1_iv", s_iv, 1);
            chk("t1_pc", s_pc, a);
            chk("t1_instr", s_in, mem_data(a));
        end

        // 2: decode stalled -> queue fills, issue stops on credit, then drains
        do_reset();
        instr_ready_i = 1'b0; imem_req_ready_i = 1'b1; lat_min = 1; lat_max = 1;
        repeat (10) cycle();
        chk("t2_issued", iss.size(), FIFO_DEPTH);
        chk("t2_req_valid", s_rv, 0);
        chk("t2_iv", s_iv, 1);
        chk("t2_head_pc", s_pc, RESET_PC);
        chk("t2_no_dlv", dlv_pc.size(), 0);
        instr_ready_i = 1'b1;
        repeat (12) cycle();
        for (int i = 0; i < 6; i++) begin
            a = RESET_PC + 32'(4 * i);
            chk("t2_drain_pc", dlv_pc[i], a);
            chk("t2_drain_instr", dlv_ins[i], mem_data(a));
        end

        // 3: redirect with two responses in flight
        do_reset();
        instr_ready_i = 1'b1; imem_req_ready_i = 1'b1; lat_min = 3; lat_max = 3;
        cycle(); cycle();
        chk("t3_inflight", iss.size(), 2);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0102;
        cycle();
        chk("t3_no_req_redirect", s_rv, 0);
        redirect_valid_i = 1'b0; clr();
        repeat (8) cycle();
        chk("t3_first_req", iss[0], 32'h8000_0100);
        chk("t3_pc0", dlv_pc[0], 32'h8000_0100);
        chk("t3_instr0", dlv_ins[0], mem_data(32'h8000_0100));
        chk("t3_pc1", dlv_pc[1], 32'h8000_0104);

        // 4: address wrap
        lat_min = 1; lat_max = 1;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        cycle();
        redirect_valid_i = 1'b0; clr();
        repeat (14) cycle();
        for (int i = 0; i < 4; i++) begin
            a = 32'hFFFF_FFF8 + 32'(4 * i);
            chk("t4_req_addr", iss[i], a);
            chk("t4_pc", dlv_pc[i], a);
            chk("t4_instr", dlv_ins[i], mem_data(a));
        end

        // 5: reset mid-operation with queued and in-flight fetches
        do_reset();
        instr_ready_i = 1'b0; imem_req_ready_i = 1'b1; lat_min = 3; lat_max = 3;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h9000_0000;
        cycle();
        redirect_valid_i = 1'b0;
        repeat (5) cycle();
        chk("t5_pre_iv", s_iv, 1);
        chk("t5_pre_pc", s_pc, 32'h9000_0000);
        rst_i = 1'b1;
        cycle(); cycle();
        chk("t5_rst_req_valid", s_rv, 0);
        chk("t5_rst_addr", s_ra, RESET_PC);
        chk("t5_rst_iv", s_iv, 0);
        chk("t5_rst_pc", s_pc, 0);
        chk("t5_rst_instr", s_in, 0);
        rst_i = 1'b0; instr_ready_i = 1'b1; lat_min = 1; lat_max = 1; clr();
        repeat (8) cycle();
        chk("t5_first_req", iss[0], RESET_PC);
        chk("t5_pc0", dlv_pc[0], RESET_PC);
        chk("t5_instr0", dlv_ins[0], mem_data(RESET_PC));
        chk("t5_pc1", dlv_pc[1], RESET_PC + 32'd4);

        // 6: random backpressure, latency and redirects against the stream model
        do_reset();
        lat_min = 1; lat_max = 5; sb_on = 1;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready_i = ($urandom_range(1, 0) == 1);
            instr_ready_i    = ($urandom_range(1, 0) == 1);
            redirect_valid_i = ($urandom_range(99, 0) < 4);
            redirect_pc_i    = $urandom;
            cycle();
        end
        redirect_valid_i = 1'b0; sb_on = 0;
        chk("t6_progress", (dlv_pc.size() > 50), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
